// File: rtl/ysyx_23060208_lsu.sv
// Load/store unit: one EXU request at a time over valid/ready, AXI4-Lite master.
// Lane alignment, byte strobes, load extension, misalign/bus-error/timeout reporting.
module ysyx_23060208_lsu #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_wen,
   input  logic [1:0]                req_size,
   input  logic                      req_unsigned,
   input  logic [ADDR_WIDTH-1:0]     req_addr,
   input  logic [DATA_WIDTH-1:0]     req_wdata,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [DATA_WIDTH-1:0]     resp_rdata,
   output logic [1:0]                resp_err,
   output logic [ADDR_WIDTH-1:0]     m_awaddr,
   output logic                      m_awvalid,
   input  logic                      m_awready,
   output logic [DATA_WIDTH-1:0]     m_wdata,
   output logic [DATA_WIDTH/8-1:0]   m_wstrb,
   output logic                      m_wvalid,
   input  logic                      m_wready,
   input  logic [1:0]                m_bresp,
   input  logic                      m_bvalid,
   output logic                      m_bready,
   output logic [ADDR_WIDTH-1:0]     m_araddr,
   output logic                      m_arvalid,
   input  logic                      m_arready,
   input  logic [DATA_WIDTH-1:0]     m_rdata,
   input  logic [1:0]                m_rresp,
   input  logic                      m_rvalid,
   output logic                      m_rready
);

   localparam int NB = DATA_WIDTH / 8;
   localparam int OW = $clog2(NB);
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] T_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_A,
      S_RD_D,
      S_WR_AW,
      S_WR_B,
      S_ERR,
      S_RESP
   } state_e;

   state_e                  state_q, state_d;
   logic                    req_ready_q, req_ready_d;
   logic [1:0]              size_q, size_d;
   logic                    uns_q, uns_d;
   logic [OW-1:0]           off_q, off_d;
   logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
   logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [NB-1:0]           wstrb_q, wstrb_d;
   logic                    awvalid_q, awvalid_d;
   logic                    wvalid_q, wvalid_d;
   logic                    bready_q, bready_d;
   logic                    arvalid_q, arvalid_d;
   logic                    rready_q, rready_d;
   logic                    resp_valid_q, resp_valid_d;
   logic [1:0]              resp_err_q, resp_err_d;
   logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
   logic [CW-1:0]           cnt_q, cnt_d;

   logic [OW-1:0]           req_off;
   logic [2:0]              amask;
   logic                    misal;
   logic                    illegal;
   logic [NB-1:0]           strb_new;
   logic [DATA_WIDTH-1:0]   wdata_new;

   logic [6:0]              nbits;
   logic [DATA_WIDTH-1:0]   rsh;
   logic [DATA_WIDTH-1:0]   lmask;
   logic                    sbit;
   logic [DATA_WIDTH-1:0]   ld_val;

   logic                    aw_ok;
   logic                    w_ok;
   logic                    in_bus;
   logic                    wd_hit;

   assign req_off   = req_addr[OW-1:0];
   assign amask     = 3'((4'd1 << req_size) - 4'd1);
   assign misal     = |(3'(req_off) & amask);
   assign illegal   = (req_size == 2'd3) && (DATA_WIDTH == 32);
   assign strb_new  = NB'((9'd1 << (4'd1 << req_size)) - 9'd1) << req_off;
   assign wdata_new = req_wdata << {req_off, 3'b000};

   assign nbits  = 7'd8 << size_q;
   assign rsh    = m_rdata >> {off_q, 3'b000};
   assign lmask  = ~({DATA_WIDTH{1'b1}} << nbits);
   assign sbit   = |(rsh & (DATA_WIDTH'(1) << (nbits - 7'd1)));
   assign ld_val = (rsh & lmask) | ({DATA_WIDTH{sbit & ~uns_q}} & ~lmask);

   // state register and all registered outputs, synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         req_ready_q  <= 1'b1;
         size_q       <= '0;
         uns_q        <= 1'b0;
         off_q        <= '0;
         awaddr_q     <= '0;
         araddr_q     <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         awvalid_q    <= 1'b0;
         wvalid_q     <= 1'b0;
         bready_q     <= 1'b0;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= '0;
         resp_rdata_q <= '0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         req_ready_q  <= req_ready_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
         off_q        <= off_d;
         awaddr_q     <= awaddr_d;
         araddr_q     <= araddr_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         awvalid_q    <= awvalid_d;
         wvalid_q     <= wvalid_d;
         bready_q     <= bready_d;
         arvalid_q    <= arvalid_d;
         rready_q     <= rready_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
         cnt_q        <= cnt_d;
      end
   end

   // next state, handshake bookkeeping and watchdog override
   always_comb begin
      state_d      = state_q;
      req_ready_d  = req_ready_q;
      size_d       = size_q;
      uns_d        = uns_q;
      off_d        = off_q;
      awaddr_d     = awaddr_q;
      araddr_d     = araddr_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      awvalid_d    = awvalid_q;
      wvalid_d     = wvalid_q;
      bready_d     = bready_q;
      arvalid_d    = arvalid_q;
      rready_d     = rready_q;
      resp_valid_d = resp_valid_q;
      resp_err_d   = resp_err_q;
      resp_rdata_d = resp_rdata_q;
      cnt_d        = '0;
      aw_ok        = 1'b0;
      w_ok         = 1'b0;
      in_bus       = 1'b0;
      wd_hit       = (TIMEOUT != 0) && (cnt_q == T_LAST);

      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               req_ready_d = 1'b0;
               size_d      = req_size;
               uns_d       = req_unsigned;
               off_d       = req_off;
               if (misal || illegal) begin
                  state_d      = S_ERR;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 2'd1;
                  resp_rdata_d = '0;
               end else if (req_wen) begin
                  state_d   = S_WR_AW;
                  awaddr_d  = req_addr;
                  wdata_d   = wdata_new;
                  wstrb_d   = strb_new;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end else begin
                  state_d   = S_RD_A;
                  araddr_d  = req_addr;
                  arvalid_d = 1'b1;
               end
            end
         end
         S_RD_A: begin
            in_bus = 1'b1;
            if (m_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = S_RD_D;
            end
         end
         S_RD_D: begin
            in_bus = 1'b1;
            if (m_rvalid) begin
               rready_d     = 1'b0;
               state_d      = S_RESP;
               resp_valid_d = 1'b1;
               if (m_rresp != 2'd0) begin
                  resp_err_d   = 2'd2;
                  resp_rdata_d = '0;
               end else begin
                  resp_err_d   = 2'd0;
                  resp_rdata_d = ld_val;
               end
            end
         end
         S_WR_AW: begin
            in_bus = 1'b1;
            aw_ok  = !awvalid_q || m_awready;
            w_ok   = !wvalid_q || m_wready;
            if (awvalid_q && m_awready) awvalid_d = 1'b0;
            if (wvalid_q && m_wready) wvalid_d = 1'b0;
            if (aw_ok && w_ok) begin
               state_d  = S_WR_B;
               bready_d = 1'b1;
            end
         end
         S_WR_B: begin
            in_bus = 1'b1;
            if (m_bvalid) begin
               bready_d     = 1'b0;
               state_d      = S_RESP;
               resp_valid_d = 1'b1;
               resp_err_d   = (m_bresp != 2'd0) ? 2'd2 : 2'd0;
               resp_rdata_d = '0;
            end
         end
         S_ERR, S_RESP: begin
            if (resp_ready) begin
               state_d      = S_IDLE;
               req_ready_d  = 1'b1;
               resp_valid_d = 1'b0;
               resp_err_d   = '0;
               resp_rdata_d = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (in_bus && (state_d == state_q)) begin
         if (wd_hit) begin
            state_d      = S_RESP;
            arvalid_d    = 1'b0;
            rready_d     = 1'b0;
            awvalid_d    = 1'b0;
            wvalid_d     = 1'b0;
            bready_d     = 1'b0;
            resp_valid_d = 1'b1;
            resp_err_d   = 2'd3;
            resp_rdata_d = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;
   assign m_awaddr   = awaddr_q;
   assign m_awvalid  = awvalid_q;
   assign m_wdata    = wdata_q;
   assign m_wstrb    = wstrb_q;
   assign m_wvalid   = wvalid_q;
   assign m_bready   = bready_q;
   assign m_araddr   = araddr_q;
   assign m_arvalid  = arvalid_q;
   assign m_rready   = rready_q;

endmodule
